// File: rtl/rv_mc_control.sv
// Main control FSM of the rv_mc multi-cycle RV32I core: sequences the shared datapath and
// unified memory per instruction, and keeps saturating cycle and retired-instruction counters.
module rv_mc_control #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic [1:0]       imm_src,
  output logic             reg_write,
  output logic             retire,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  logic pc_update;
  logic branch;
  logic retire_raw;

  // Unsupported funct3 values fall back to add rather than trapping.
  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_en);
    logic [2:0] ctl;
    ctl = ALU_ADD;
    unique case (f3)
      3'b000:  ctl = sub_en ? ALU_SUB : ALU_ADD;
      3'b010:  ctl = ALU_SLT;
      3'b110:  ctl = ALU_OR;
      3'b111:  ctl = ALU_AND;
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [1:0] imm_decode(input logic [6:0] opcode);
    logic [1:0] sel;
    sel = 2'b00;
    unique case (opcode)
      OP_SW:   sel = 2'b01;
      OP_BEQ:  sel = 2'b10;
      OP_JAL:  sel = 2'b11;
      default: sel = 2'b00;
    endcase
    return sel;
  endfunction

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q       <= FETCH;
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_update   = 1'b0;
    branch      = 1'b0;
    retire_raw  = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RD2;
    alu_control = ALU_ADD;
    reg_write   = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      FETCH: begin
        adr_src    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        // Branch target is computed here so BEQ can use ALUOut directly.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        unique case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        state_d   = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        retire_raw = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        mem_write  = mem_ready;
        retire_raw = mem_ready;
        if (mem_ready) state_d = FETCH;
      end
      EXECUTER: begin
        alu_src_a   = SRCA_RD1;
        alu_src_b   = SRCB_RD2;
        alu_control = alu_decode(funct3, funct7b5);
        state_d     = ALUWB;
      end
      EXECUTEI: begin
        alu_src_a   = SRCA_RD1;
        alu_src_b   = SRCB_IMM;
        alu_control = alu_decode(funct3, 1'b0);
        state_d     = ALUWB;
      end
      ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        retire_raw = 1'b1;
        state_d    = FETCH;
      end
      BEQ: begin
        alu_src_a   = SRCA_RD1;
        alu_src_b   = SRCB_RD2;
        alu_control = ALU_SUB;
        result_src  = RES_ALUOUT;
        branch      = 1'b1;
        retire_raw  = 1'b1;
        state_d     = FETCH;
      end
      JAL: begin
        // PC <- target from ALUOut while the ALU forms the link address OldPC+4.
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_update  = 1'b1;
        state_d    = ALUWB;
      end
      TRAP: begin
        halted  = 1'b1;
        state_d = TRAP;
      end
      default: state_d = FETCH;
    endcase
  end

  // A reset landing on a retire cycle discards that instruction.
  assign retire   = retire_raw & rst;
  assign pc_write = pc_update | (branch & zero);
  assign imm_src  = imm_decode(op);

  always_comb begin
    cycle_count_d = sat_inc(cycle_count_q);
    instr_count_d = retire ? sat_inc(instr_count_q) : instr_count_q;
  end

  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_rv_mc_control.sv
// Directed bench for rv_mc_control: per-cycle control vectors for instruction sequences,
// plus hand-written reset, trap and counter-saturation sequences.
module tb_rv_mc_control;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  localparam logic [2:0] A_ADD = 3'b000;
  localparam logic [2:0] A_SUB = 3'b001;
  localparam logic [2:0] A_AND = 3'b010;
  localparam logic [2:0] A_OR  = 3'b011;
  localparam logic [2:0] A_SLT = 3'b101;

  // Vector layout: pc_write adr_src mem_write ir_write result_src alu_src_a alu_src_b alu_control reg_write retire halted
  localparam logic [15:0] E_FETCH  = 16'b1_0_0_1_10_00_10_000_0_0_0;
  localparam logic [15:0] E_FETCHW = 16'b0_0_0_0_10_00_10_000_0_0_0;
  localparam logic [15:0] E_DEC    = 16'b0_0_0_0_00_01_01_000_0_0_0;
  localparam logic [15:0] E_MADR   = 16'b0_0_0_0_00_10_01_000_0_0_0;
  localparam logic [15:0] E_MRD    = 16'b0_1_0_0_00_00_00_000_0_0_0;
  localparam logic [15:0] E_MWB    = 16'b0_0_0_0_01_00_00_000_1_1_0;
  localparam logic [15:0] E_MWR    = 16'b0_1_1_0_00_00_00_000_0_1_0;
  localparam logic [15:0] E_MWRW   = 16'b0_1_0_0_00_00_00_000_0_0_0;
  localparam logic [15:0] E_AWB    = 16'b0_0_0_0_00_00_00_000_1_1_0;
  localparam logic [15:0] E_BEQT   = 16'b1_0_0_0_00_10_00_001_0_1_0;
  localparam logic [15:0] E_BEQN   = 16'b0_0_0_0_00_10_00_001_0_1_0;
  localparam logic [15:0] E_JAL    = 16'b1_0_0_0_00_01_10_000_0_0_0;
  localparam logic [15:0] E_TRAP   = 16'b0_0_0_0_00_00_00_000_0_0_1;

  localparam logic [15:0] M_EN  = 16'b1_0_1_1_00_00_00_000_1_1_1;
  localparam logic [15:0] M_ADR = 16'b0_1_0_0_00_00_00_000_0_0_0;
  localparam logic [15:0] M_RS  = 16'b0_0_0_0_11_00_00_000_0_0_0;
  localparam logic [15:0] M_ALU = 16'b0_0_0_0_00_11_11_111_0_0_0;
  localparam logic [15:0] K_ALL = 16'hFFFF;
  localparam logic [15:0] K_DEC = M_EN | M_ALU;
  localparam logic [15:0] K_MEM = M_EN | M_ADR | M_RS;
  localparam logic [15:0] K_WB  = M_EN | M_RS;
  localparam logic [15:0] K_BR  = M_EN | M_RS | M_ALU;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        mr;
    logic [15:0] e;
    logic [15:0] m;
  } vec_t;

  logic        clock = 1'b0;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, adr_src, mem_write, ir_write, reg_write, retire, halted;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_control;
  logic [31:0] cycle_count, instr_count;

  logic        rst4;
  logic [17:0] ctl4;
  logic [3:0]  cycle_count4, instr_count4;

  vec_t tbl[$];
  int   total = 0;
  int   bad = 0;

  always #5 clock = ~clock;

  rv_mc_control #(.CNT_W(32)) dut (
    .clock(clock), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .reg_write(reg_write), .retire(retire), .halted(halted),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  // Narrow-counter instance running addi back to back.
  rv_mc_control #(.CNT_W(4)) dut4 (
    .clock(clock), .rst(rst4), .op(OP_I), .funct3(3'b000), .funct7b5(1'b0),
    .zero(1'b0), .mem_ready(1'b1), .pc_write(ctl4[17]), .adr_src(ctl4[16]),
    .mem_write(ctl4[15]), .ir_write(ctl4[14]), .result_src(ctl4[13:12]),
    .alu_src_a(ctl4[11:10]), .alu_src_b(ctl4[9:8]), .alu_control(ctl4[7:5]),
    .imm_src(ctl4[4:3]), .reg_write(ctl4[2]), .retire(ctl4[1]), .halted(ctl4[0]),
    .cycle_count(cycle_count4), .instr_count(instr_count4)
  );

  function automatic logic [15:0] exr(input logic [2:0] a);
    return {4'b0000, 2'b00, 2'b10, 2'b00, a, 3'b000};
  endfunction

  function automatic logic [15:0] exi(input logic [2:0] a);
    return {4'b0000, 2'b00, 2'b10, 2'b01, a, 3'b000};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic z, input logic mr, input logic [15:0] e, input logic [15:0] m);
    vec_t v;
    v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.mr = mr; v.e = e; v.m = m;
    tbl.push_back(v);
  endtask

  task automatic add_fd(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    add(o, f3, f7, 1'b0, 1'b1, E_FETCH, K_ALL);
    add(o, f3, f7, 1'b1, 1'b1, E_DEC, K_DEC);
  endtask

  task automatic add_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic [15:0] e);
    add_fd(o, f3, f7);
    add(o, f3, f7, 1'b0, 1'b1, e, K_DEC);
    add(o, f3, f7, 1'b0, 1'b1, E_AWB, K_WB);
  endtask

  // Apply one cycle of inputs, compare at the falling edge, then advance past the rising edge.
  task automatic step(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                      input logic mr, input logic [15:0] e, input logic [15:0] m, input int tag);
    logic [15:0] got;
    op = o; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = mr;
    @(negedge clock);
    got = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
           alu_control, reg_write, retire, halted};
    total++;
    if ((got & m) !== (e & m)) begin
      bad++;
      $display("FAIL row%0d ctl: got %b expected %b (mask %b)", tag, got, e, m);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1;
    int c0;
    int i0;
    int r4;

    // Straight-line program: lw, sw, add, addi, beq taken, jal.
    add_fd(OP_LW, 3'b010, 1'b0);
    add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, E_MADR, K_DEC);
    add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, E_MRD, K_MEM);
    add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, E_MWB, K_WB);
    add_fd(OP_SW, 3'b010, 1'b0);
    add(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, E_MADR, K_DEC);
    add(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, E_MWR, K_MEM);
    add_alu(OP_R, 3'b000, 1'b0, exr(A_ADD));
    add_alu(OP_I, 3'b000, 1'b0, exi(A_ADD));
    add_fd(OP_BEQ, 3'b000, 1'b0);
    add(OP_BEQ, 3'b000, 1'b0, 1'b1, 1'b1, E_BEQT, K_BR);
    add_fd(OP_JAL, 3'b000, 1'b0);
    add(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, E_JAL, K_BR);
    add(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, E_AWB, K_WB);
    n1 = tbl.size();

    // sw with fetch and write stalls
    add(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, E_FETCHW, K_ALL);
    add_fd(OP_SW, 3'b010, 1'b0);
    add(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, E_MADR, K_DEC);
    add(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, E_MWRW, K_MEM);
    add(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, E_MWR, K_MEM);
    // beq not taken
    add_fd(OP_BEQ, 3'b000, 1'b0);
    add(OP_BEQ, 3'b000, 1'b0, 1'b0, 1'b1, E_BEQN, K_BR);
    // ALU op decode
    add_alu(OP_R, 3'b000, 1'b1, exr(A_SUB));
    add_alu(OP_R, 3'b110, 1'b0, exr(A_OR));
    add_alu(OP_R, 3'b111, 1'b0, exr(A_AND));
    add_alu(OP_R, 3'b001, 1'b1, exr(A_ADD));
    add_alu(OP_I, 3'b000, 1'b1, exi(A_ADD));
    add_alu(OP_I, 3'b010, 1'b0, exi(A_SLT));
    add_alu(OP_I, 3'b111, 1'b1, exi(A_AND));
    // lw stalled three cycles in MEMREAD: retires on its 8th cycle
    add_fd(OP_LW, 3'b010, 1'b0);
    add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, E_MADR, K_DEC);
    for (int k = 0; k < 3; k++) add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, E_MRD, K_MEM);
    add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, E_MRD, K_MEM);
    add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, E_MWB, K_WB);
    // jal updates PC regardless of mem_ready
    add_fd(OP_JAL, 3'b000, 1'b0);
    add(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, E_JAL, K_BR);
    add(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, E_AWB, K_WB);
    // illegal opcode
    add_fd(OP_BAD, 3'b000, 1'b0);
    add(OP_BAD, 3'b000, 1'b0, 1'b1, 1'b1, E_TRAP, M_EN);
    add(OP_BAD, 3'b000, 1'b0, 1'b1, 1'b0, E_TRAP, M_EN);
    add(OP_BAD, 3'b000, 1'b0, 1'b0, 1'b1, E_TRAP, M_EN);

    rst = 1'b0; rst4 = 1'b0;
    op = OP_LW; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;

    // imm_src depends on op alone
    op = OP_LW;  #1; chk("imm_lw", 32'(imm_src), 32'd0);
    op = OP_SW;  #1; chk("imm_sw", 32'(imm_src), 32'd1);
    op = OP_BEQ; #1; chk("imm_beq", 32'(imm_src), 32'd2);
    op = OP_JAL; #1; chk("imm_jal", 32'(imm_src), 32'd3);

    @(posedge clock);
    #1;
    step(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, E_FETCH, K_ALL, -1);
    chk("rst_cycle_count", cycle_count, 32'd0);
    chk("rst_instr_count", instr_count, 32'd0);
    rst = 1'b1; rst4 = 1'b1;

    for (int i = 0; i < n1; i++)
      step(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].mr, tbl[i].e, tbl[i].m, i);
    chk("prog_instr_count", instr_count, 32'd6);
    chk("prog_cycle_count", cycle_count, 32'd24);
    chk("w4_cycle_sat_early", 32'(cycle_count4), 32'd15);
    chk("w4_instr_mid", 32'(instr_count4), 32'd6);

    for (int i = n1; i < tbl.size(); i++)
      step(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].mr, tbl[i].e, tbl[i].m, i);

    // TRAP: counters keep running, nothing retires
    c0 = cycle_count;
    i0 = instr_count;
    repeat (5) @(posedge clock);
    #1;
    chk("trap_cycle_count", cycle_count, 32'(c0 + 5));
    chk("trap_instr_count", instr_count, 32'(i0));
    chk("trap_halted", 32'(halted), 32'd1);

    // Reset out of TRAP, retire one addi, then reset in the middle of lw's MEMREAD
    rst = 1'b0;
    @(posedge clock);
    #1;
    rst = 1'b1;
    chk("rst2_cycle_count", cycle_count, 32'd0);
    step(OP_I, 3'b000, 1'b0, 1'b0, 1'b1, E_FETCH, K_ALL, 100);
    step(OP_I, 3'b000, 1'b0, 1'b0, 1'b1, E_DEC, K_DEC, 101);
    step(OP_I, 3'b000, 1'b0, 1'b0, 1'b1, exi(A_ADD), K_DEC, 102);
    step(OP_I, 3'b000, 1'b0, 1'b0, 1'b1, E_AWB, K_WB, 103);
    chk("addi_instr_count", instr_count, 32'd1);
    step(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, E_FETCH, K_ALL, 104);
    step(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, E_DEC, K_DEC, 105);
    step(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, E_MADR, K_DEC, 106);
    rst = 1'b0;
    step(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, E_MRD, K_MEM, 107);
    rst = 1'b1;
    chk("midrst_cycle_count", cycle_count, 32'd0);
    chk("midrst_instr_count", instr_count, 32'd0);
    step(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, E_FETCH, K_ALL, 108);

    // Narrow counters: well past 80 cycles both sit at 15, retires still pulse every 4 cycles
    r4 = 0;
    repeat (20) begin
      @(negedge clock);
      if (ctl4[1]) r4++;
    end
    chk("w4_retire_pulses", 32'(r4), 32'd5);
    chk("w4_cycle_sat", 32'(cycle_count4), 32'd15);
    chk("w4_instr_sat", 32'(instr_count4), 32'd15);
    chk("w4_ctl_known", 32'($isunknown(ctl4)), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
